rgb_byte_unpacker: RTL and testbench

//   Upstream feeder for the grayscale pipeline. Accepts an 8-bit byte stream (R,G,B order per

---
 rtl/rgb_byte_unpacker_if.sv | 9 +
 rtl/rgb_byte_unpacker.sv | 122 ++++++++++++
 tb/tb_rgb_byte_unpacker.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_byte_unpacker_if.sv
// Byte stream into the RGB unpacker: source drives data/valid, unpacker returns ready.
interface rgb_byte_unpacker_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/rgb_byte_unpacker.sv
// Assembles R,G,B bytes into 16-bit channel words for the gray stage and tracks raster
// position, delaying valid/sof/eol/eof so they line up with the grayscale result.
module rgb_byte_unpacker #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int GRAY_LAT = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync_clr,
    rgb_byte_unpacker_if.slave  s,
    output logic [15:0]         red,
    output logic [15:0]         green,
    output logic [15:0]         blue,
    output logic                pix_valid,
    output logic                gray_valid,
    output logic                gray_sof,
    output logic                gray_eol,
    output logic                gray_eof
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;

    phase_t          phase, phase_nxt;
    logic            accept;
    logic            load_r, load_g, pix_done;
    logic [7:0]      r_hold, g_hold;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            at_first, at_eol, at_eof;
    logic            sof_q, eol_q, eof_q;
    logic [GRAY_LAT-1:0][3:0] dly;

    assign accept   = s.s_valid & s.s_ready;
    assign at_first = (col == '0) && (row == '0);
    assign at_eol   = (col == COL_LAST);
    assign at_eof   = at_eol && (row == ROW_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) phase <= PH_R;
        else        phase <= phase_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        phase_nxt = phase;
        load_r    = 1'b0;
        load_g    = 1'b0;
        pix_done  = 1'b0;
        if (sync_clr) begin
            // Resync wins; a byte arriving with it becomes the R byte of pixel (0,0).
            load_r    = accept;
            phase_nxt = accept ? PH_G : PH_R;
        end else if (accept) begin
            unique case (phase)
                PH_R: begin load_r = 1'b1; phase_nxt = PH_G; end
                PH_G: begin load_g = 1'b1; phase_nxt = PH_B; end
                PH_B: begin pix_done = 1'b1; phase_nxt = PH_R; end
                default: phase_nxt = PH_R;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.s_ready <= 1'b0;
            r_hold    <= '0;
            g_hold    <= '0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            pix_valid <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
            col       <= '0;
            row       <= '0;
        end else begin
            s.s_ready <= 1'b1;
            pix_valid <= pix_done;
            sof_q     <= pix_done & at_first;
            eol_q     <= pix_done & at_eol;
            eof_q     <= pix_done & at_eof;
            if (load_r) r_hold <= s.s_data;
            if (load_g) g_hold <= s.s_data;
            if (pix_done) begin
                red   <= {r_hold, 8'h00};
                green <= {g_hold, 8'h00};
                blue  <= {s.s_data, 8'h00};
            end
            if (sync_clr) begin
                col <= '0;
                row <= '0;
            end else if (pix_done) begin
                if (at_eol) begin
                    col <= '0;
                    row <= at_eof ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Flag bits are already zero outside valid pixels, so the delayed copies stay qualified.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the delay line is reset so no stale gray_valid survives an async reset.
        if (!rst_n) begin
            dly <= '0;
        end else begin
            dly[0] <= {pix_valid, sof_q, eol_q, eof_q};
            for (int i = 1; i < GRAY_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign {gray_valid, gray_sof, gray_eol, gray_eof} = dly[GRAY_LAT-1];
endmodule

// File: tb/tb_rgb_byte_unpacker.sv
// Directed bench for rgb_byte_unpacker on a 4x2 raster with a 5-cycle gray latency.
module tb_rgb_byte_unpacker;
    localparam int IMG_W    = 4;
    localparam int IMG_H    = 2;
    localparam int GRAY_LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync_clr = 1'b0;
    logic [15:0] red, green, blue;
    logic        pix_valid, gray_valid, gray_sof, gray_eol, gray_eof;

    rgb_byte_unpacker_if bus();

    rgb_byte_unpacker #(.IMG_W(IMG_W), .IMG_H(IMG_H), .GRAY_LAT(GRAY_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .s(bus),
        .red(red), .green(green), .blue(blue), .pix_valid(pix_valid),
        .gray_valid(gray_valid), .gray_sof(gray_sof), .gray_eol(gray_eol), .gray_eof(gray_eof)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] r, g, b;
    } pix_t;
    typedef struct packed {
        logic [31:0] cyc;
        logic        sof, eol, eof;
    } gray_t;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    pix_t  pix_q[$];
    gray_t gray_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid)  pix_q.push_back('{cyc: cyc, r: red, g: green, b: blue});
            if (gray_valid) gray_q.push_back('{cyc: cyc, sof: gray_sof, eol: gray_eol, eof: gray_eof});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
    endtask

    task automatic send_sync(input logic with_byte, input logic [7:0] b);
        sync_clr    = 1'b1;
        bus.s_valid = with_byte;
        bus.s_data  = b;
        @(posedge clk); #1;
        sync_clr    = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        sync_clr = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        pix_q.delete();
        gray_q.delete();
    endtask

    // Waits (bounded) for n delayed pixels, then lets the pipe drain and requires exactly n.
    task automatic settle_gray(input int n, input string name);
        int k = 0;
        while (gray_q.size() < n && k < 60) begin idle(1); k++; end
        idle(GRAY_LAT + 3);
        checks++;
        if (gray_q.size() != n) begin
            failures++;
            $display("FAIL %s_gray_count: got %0d, expected %0d", name, gray_q.size(), n);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({bus.s_ready, red, green, blue, pix_valid, gray_valid, gray_sof, gray_eol, gray_eof} !== '0) begin
            failures++;
            $display("FAIL reset_state: ready=%b red=%h green=%h blue=%h pv=%b gv=%b", bus.s_ready, red, green, blue, pix_valid, gray_valid);
        end
        idle(2);
        rst_n = 1'b1;
        checks++;
        if (bus.s_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge: got %b, expected 0", bus.s_ready);
        end
        idle(1);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_edge: got %b, expected 1", bus.s_ready);
        end
        send(8'd1); send(8'd2); send(8'd3);
        send(8'd10); send(8'd20);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.s_ready, red, green, blue, pix_valid, gray_valid} !== '0) begin
            failures++;
            $display("FAIL reset_mid_pixel: ready=%b red=%h green=%h blue=%h pv=%b gv=%b", bus.s_ready, red, green, blue, pix_valid, gray_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        send(8'd10); send(8'd20); send(8'd30);
        checks++;
        if ({pix_valid, red, green, blue} !== {1'b1, 16'h0A00, 16'h1400, 16'h1E00}) begin
            failures++;
            $display("FAIL pixel_after_reset: pv=%b red=%h green=%h blue=%h, expected 1 0a00 1400 1e00", pix_valid, red, green, blue);
        end
        idle(1);
        checks++;
        if ({pix_valid, red} !== {1'b0, 16'h0A00}) begin
            failures++;
            $display("FAIL pix_valid_one_cycle: pv=%b red=%h, expected 0 0a00", pix_valid, red);
        end
    endtask

    task automatic test_latency();
        do_reset();
        send(8'hFF); send(8'hFF); send(8'hFF);
        settle_gray(1, "latency");
        checks++;
        if (pix_q.size() != 1 || gray_q.size() != 1) begin
            failures++;
            $display("FAIL latency_counts: pix=%0d gray=%0d, expected 1 1", pix_q.size(), gray_q.size());
        end else begin
            checks++;
            if (gray_q[0].cyc - pix_q[0].cyc != GRAY_LAT) begin
                failures++;
                $display("FAIL latency_cycles: got %0d, expected %0d", gray_q[0].cyc - pix_q[0].cyc, GRAY_LAT);
            end
            checks++;
            if ({gray_q[0].sof, gray_q[0].eol, gray_q[0].eof, pix_q[0].r, pix_q[0].b} !== {3'b100, 16'hFF00, 16'hFF00}) begin
                failures++;
                $display("FAIL latency_flags: sof/eol/eof=%b%b%b red=%h blue=%h, expected 100 ff00 ff00",
                         gray_q[0].sof, gray_q[0].eol, gray_q[0].eof, pix_q[0].r, pix_q[0].b);
            end
        end
    endtask

    // Nine back-to-back pixels: eol on 3 and 7, eof on 7, sof on 0 and again on 8.
    task automatic test_raster_wrap();
        logic [8:0] sof_exp = 9'b1_0000_0001;
        logic [8:0] eol_exp = 9'b0_1000_1000;
        logic [8:0] eof_exp = 9'b0_1000_0000;
        do_reset();
        for (int i = 0; i < 27; i++) send(8'(i));
        settle_gray(9, "raster");
        for (int i = 0; i < 9 && i < gray_q.size() && i < pix_q.size(); i++) begin
            checks++;
            if ({gray_q[i].sof, gray_q[i].eol, gray_q[i].eof} !== {sof_exp[i], eol_exp[i], eof_exp[i]}) begin
                failures++;
                $display("FAIL raster_flags[%0d]: got %b%b%b, expected %b%b%b", i,
                         gray_q[i].sof, gray_q[i].eol, gray_q[i].eof, sof_exp[i], eol_exp[i], eof_exp[i]);
            end
            if (i > 0) begin
                checks++;
                if (pix_q[i].cyc - pix_q[i-1].cyc != 3) begin
                    failures++;
                    $display("FAIL back_to_back_spacing[%0d]: got %0d cycles, expected 3", i, pix_q[i].cyc - pix_q[i-1].cyc);
                end
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int k = 0; k < 27; k++) begin
            idle($urandom_range(0, 7));
            send(8'(k * 7 + 3));
        end
        settle_gray(9, "gaps");
        checks++;
        if (pix_q.size() != 9) begin
            failures++;
            $display("FAIL gaps_pix_count: got %0d, expected 9", pix_q.size());
        end
        for (int i = 0; i < 9 && i < gray_q.size() && i < pix_q.size(); i++) begin
            logic [7:0] er, eg, eb;
            logic       esof, eeol, eeof;
            er   = 8'((3 * i) * 7 + 3);
            eg   = 8'((3 * i + 1) * 7 + 3);
            eb   = 8'((3 * i + 2) * 7 + 3);
            esof = (i % IMG_W == 0) && ((i / IMG_W) % IMG_H == 0);
            eeol = (i % IMG_W == IMG_W - 1);
            eeof = eeol && ((i / IMG_W) % IMG_H == IMG_H - 1);
            checks++;
            if ({pix_q[i].r, pix_q[i].g, pix_q[i].b, gray_q[i].sof, gray_q[i].eol, gray_q[i].eof}
                !== {er, 8'h00, eg, 8'h00, eb, 8'h00, esof, eeol, eeof}) begin
                failures++;
                $display("FAIL gaps_pixel[%0d]: got %h %h %h %b%b%b, expected %h00 %h00 %h00 %b%b%b", i,
                         pix_q[i].r, pix_q[i].g, pix_q[i].b, gray_q[i].sof, gray_q[i].eol, gray_q[i].eof,
                         er, eg, eb, esof, eeol, eeof);
            end
        end
    endtask

    task automatic test_resync();
        logic [23:0] exp_pix [4];
        exp_pix[0] = {8'd1, 8'd2, 8'd3};
        exp_pix[1] = {8'd40, 8'd50, 8'd60};
        exp_pix[2] = {8'd80, 8'd90, 8'd100};
        exp_pix[3] = {8'd13, 8'd14, 8'd15};
        do_reset();
        send(8'd1); send(8'd2); send(8'd3);
        send(8'd7); send(8'd8);
        send_sync(1'b1, 8'd40);
        checks++;
        if ({pix_valid, red} !== {1'b0, 16'h0100}) begin
            failures++;
            $display("FAIL resync_holds_outputs: pv=%b red=%h, expected 0 0100", pix_valid, red);
        end
        send(8'd50); send(8'd60);
        send(8'd70);
        send_sync(1'b0, 8'd0);
        send(8'd80); send(8'd90); send(8'd100);
        send(8'd11); send(8'd12);
        send_sync(1'b1, 8'd13);
        send(8'd14); send(8'd15);
        settle_gray(4, "resync");
        for (int i = 0; i < 4 && i < gray_q.size() && i < pix_q.size(); i++) begin
            checks++;
            if ({pix_q[i].r[15:8], pix_q[i].g[15:8], pix_q[i].b[15:8], gray_q[i].sof} !== {exp_pix[i], 1'b1}) begin
                failures++;
                $display("FAIL resync_pixel[%0d]: got %h %h %h sof=%b, expected %h sof=1", i,
                         pix_q[i].r, pix_q[i].g, pix_q[i].b, gray_q[i].sof, exp_pix[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) send(8'(8'h21 + i));
        idle(GRAY_LAT - 3);
        checks++;
        if (gray_valid !== 1'b1) begin
            failures++;
            $display("FAIL async_pre_gray_valid: got %b, expected 1", gray_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gray_valid, gray_sof, pix_valid} !== 3'b000) begin
            failures++;
            $display("FAIL async_gray_drop: gv=%b sof=%b pv=%b, expected 000", gray_valid, gray_sof, pix_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pix_q.delete();
        gray_q.delete();
        idle(GRAY_LAT + 8);
        checks++;
        if (gray_q.size() != 0 || pix_q.size() != 0) begin
            failures++;
            $display("FAIL async_no_stale: gray=%0d pix=%0d, expected 0 0", gray_q.size(), pix_q.size());
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        test_reset();
        test_latency();
        test_raster_wrap();
        test_gaps();
        test_resync();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
